// File: rtl/ps2_receiver.sv
// PS/2 serial receiver: synchronizes and deglitches ps2_clk, then frames start/8 data/odd parity/stop bits.
// Decoded byte and its two hex digits update one cycle after the stop-bit falling edge.
module ps2_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic [3:0] hex_hi,
    output logic [3:0] hex_lo,
    output logic       code_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_clk_q, filt_clk_d, filt_prev_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          code_valid_q, code_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          fall_evt, timeout;

    // Synchronizers and filtered clock idle high so reset release never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            filt_clk_q   <= 1'b1;
            filt_prev_q  <= 1'b1;
            filt_cnt_q   <= '0;
            tmo_q        <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            scan_code_q  <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_s1_q     <= ps2_clk;
            clk_s2_q     <= clk_s1_q;
            dat_s1_q     <= ps2_data;
            dat_s2_q     <= dat_s1_q;
            filt_clk_q   <= filt_clk_d;
            filt_prev_q  <= filt_clk_q;
            filt_cnt_q   <= filt_cnt_d;
            tmo_q        <= tmo_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            scan_code_q  <= scan_code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_clk_d = clk_s2_q;
            else filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    assign fall_evt = filt_prev_q & ~filt_clk_q;
    assign timeout  = (state_q != IDLE) && !fall_evt && (tmo_q == TW'(TIMEOUT_CYCLES));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == IDLE || fall_evt) tmo_d = '0;
        else if (tmo_q != TW'(TIMEOUT_CYCLES)) tmo_d = tmo_q + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        scan_code_d  = scan_code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (timeout) begin
            state_d     = IDLE;
            shift_d     = '0;
            frame_err_d = 1'b1;
        end else if (fall_evt) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = dat_s2_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    // Odd parity: the nine bits together must hold an odd number of ones.
                    if (dat_s2_q && (^{shift_q, parity_q})) begin
                        scan_code_d  = shift_q;
                        code_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        scan_code  = scan_code_q;
        hex_hi     = scan_code_q[7:4];
        hex_lo     = scan_code_q[3:0];
        code_valid = code_valid_q;
        frame_err  = frame_err_q;
    end
endmodule

// File: tb/tb_ps2_receiver.sv
// Frame-level bench for ps2_receiver: table of frames plus hand sequences for glitch, timeout and reset.
module tb_ps2_receiver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic [3:0] hex_hi, hex_lo;
    logic       code_valid, frame_err, busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_ok;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] last_code = 8'h00;
    logic       prev_pulse = 1'b0;
    vec_t       vecs[9];

    ps2_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scan_code(scan_code), .hex_hi(hex_hi), .hex_lo(hex_lo),
        .code_valid(code_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        ps2_clk  = 1'b1;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic expect_pulse(input logic ok, input logic [7:0] d);
        exp_t x;
        if (ok) last_code = d;
        x.is_err = !ok;
        x.code   = last_code;
        exp_q.push_back(x);
    endtask

    task automatic go_idle(input int n);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (code_valid || frame_err) begin
            check("pulse_exclusive", 32'(code_valid & frame_err), 32'd0);
            check("pulse_width", 32'(prev_pulse), 32'd0);
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_pulse: code_valid=%0d frame_err=%0d scan_code=0x%0h, expected no pulse",
                         code_valid, frame_err, scan_code);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
                check("scan_code", 32'(scan_code), 32'(e.code));
                check("hex_hi", 32'(hex_hi), 32'(e.code[7:4]));
                check("hex_lo", 32'(hex_lo), 32'(e.code[3:0]));
            end
        end
        prev_pulse = code_valid | frame_err;
    end

    initial begin
        int  n;
        logic seen;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h1C, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{8'h80, 1'b0, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_scan_code", 32'(scan_code), 32'h00);
        check("rst_hex_hi", 32'(hex_hi), 32'h0);
        check("rst_hex_lo", 32'(hex_lo), 32'h0);
        check("rst_code_valid", 32'(code_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        go_idle(20);

        // Back-to-back frames: each next start bit follows the previous stop bit directly.
        foreach (vecs[i]) begin
            expect_pulse(vecs[i].exp_ok, vecs[i].data);
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
        end
        go_idle(40);
        check("after_table_queue", 32'(exp_q.size()), 32'd0);
        check("after_table_code", 32'(scan_code), 32'h80);
        check("after_table_busy", 32'(busy), 32'd0);

        // 3-cycle glitch ignored, 4-cycle low accepted as a start bit.
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen |= busy;
        end
        check("glitch3_busy", 32'(seen), 32'd0);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch4_busy", 32'(busy), 32'd1);
        expect_pulse(1'b0, 8'h00);
        ps2_data = 1'b1;
        repeat (260) @(negedge clk);
        check("glitch4_timeout_busy", 32'(busy), 32'd0);
        check("glitch4_queue", 32'(exp_q.size()), 32'd0);

        // Partial frame then silence: timeout roughly 200 cycles after the last falling edge.
        expect_pulse(1'b0, 8'h00);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b0;
        ps2_clk  = 1'b1;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 20) begin
                ps2_clk  = 1'b1;
                ps2_data = 1'b1;
            end
            seen = frame_err;
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_in_window", 32'((n >= 200) && (n <= 215)), 32'd1);
        @(negedge clk);
        check("timeout_busy", 32'(busy), 32'd0);
        go_idle(20);

        // Reset after bit 5 of a frame, then a fresh full frame.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_clk = 1'b1;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_code = 8'h00;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_scan_code", 32'(scan_code), 32'h00);
        go_idle(30);
        expect_pulse(1'b1, 8'h3A);
        send_frame(8'h3A, 1'b1, 1'b1);
        go_idle(40);
        check("final_scan_code", 32'(scan_code), 32'h3A);

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
